// File: rtl/gestor_puertas.sv
// Elevator door manager: latches hall/cabin requests, serves the current floor and sequences the door motor.
// Optional macro OBSTACULO_EN enables the door-edge obstruction sensor.
module gestor_puertas #(
  parameter int T_ESPERA = 50,
  parameter int T_MOV    = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] botones,
  input  logic [3:0] estado,
  input  logic       fin_abierta,
  input  logic       fin_cerrada,
  input  logic       obstaculo,
  output logic [9:0] s,
  output logic       esperar,
  output logic [1:0] puerta,
  output logic       falla
);

  typedef enum logic [1:0] {CERRADA, ABRIENDO, ABIERTA, CERRANDO} fase_t;

  localparam logic [9:0] T_MOV_C = 10'(T_MOV);
  localparam logic [7:0] T_ESP_C = 8'(T_ESPERA);

  // All request bits belonging to each floor index (cabin + hall buttons)
  localparam logic [9:0] PISO0 = 10'h041;
  localparam logic [9:0] PISO1 = 10'h086;
  localparam logic [9:0] PISO2 = 10'h118;
  localparam logic [9:0] PISO3 = 10'h220;

  fase_t      st, st_next;
  logic [9:0] cnt_mov, cnt_mov_next, cnt_inc;
  logic [7:0] cnt_esp, cnt_esp_next;
  logic [9:0] s_next, servido;
  logic       falla_next, pulsado, timeout, obst_act;
  logic [1:0] puerta_next;
  logic       esperar_next;

`ifdef OBSTACULO_EN
  assign obst_act = obstaculo;
`else
  logic obst_unused;
  assign obst_act    = 1'b0;
  assign obst_unused = obstaculo;
`endif

  // Requests cleared when the door opens at floor f heading in direction d.
  // The opposite hall call is also taken when nothing is pending further along.
  function automatic logic [9:0] conjunto_servido(input logic [9:0] pend,
                                                  input logic [1:0] f,
                                                  input logic       d);
    logic [9:0] m, opuesto, mas_alla;
    m        = '0;
    opuesto  = '0;
    mas_alla = '0;
    case (f)
      2'd0: m = PISO0;
      2'd1: begin
        m        = d ? 10'h084 : 10'h082;
        opuesto  = d ? 10'h002 : 10'h004;
        mas_alla = d ? (PISO2 | PISO3) : PISO0;
      end
      2'd2: begin
        m        = d ? 10'h110 : 10'h108;
        opuesto  = d ? 10'h008 : 10'h010;
        mas_alla = d ? PISO3 : (PISO0 | PISO1);
      end
      default: m = PISO3;
    endcase
    if ((pend & mas_alla) == '0) m = m | opuesto;
    return m;
  endfunction

  assign servido = conjunto_servido(s, estado[1:0], estado[2]);
  assign pulsado = |(botones & servido);
  assign cnt_inc = (cnt_mov == T_MOV_C) ? cnt_mov : cnt_mov + 10'd1;
  assign timeout = (cnt_inc == T_MOV_C);

  always_comb begin
    st_next      = st;
    cnt_esp_next = cnt_esp;
    falla_next   = falla;
    s_next       = s | botones;
    case (st)
      CERRADA: begin
        if (!estado[3] && |((s | botones) & servido)) st_next = ABRIENDO;
      end
      ABRIENDO: begin
        if (fin_abierta) begin
          st_next = ABIERTA;
        end else if (timeout) begin
          st_next    = ABIERTA;
          falla_next = 1'b1;
        end
        if (st_next != ABRIENDO) s_next = (s | botones) & ~servido;
      end
      ABIERTA: begin
        if (pulsado || obst_act) begin
          cnt_esp_next = T_ESP_C;
        end else if (cnt_esp <= 8'd1) begin
          cnt_esp_next = 8'd0;
          st_next      = CERRANDO;
        end else begin
          cnt_esp_next = cnt_esp - 8'd1;
        end
      end
      CERRANDO: begin
        // Both limit switches high is treated as "not closed"
        if (pulsado || obst_act) begin
          st_next = ABRIENDO;
        end else if (fin_cerrada && !fin_abierta) begin
          st_next = CERRADA;
        end else if (timeout) begin
          st_next    = ABRIENDO;
          falla_next = 1'b1;
        end
      end
      default: st_next = CERRANDO;
    endcase

    if (st_next == ABIERTA && st != ABIERTA) cnt_esp_next = T_ESP_C;
    cnt_mov_next = (st_next != st) ? 10'd0 : cnt_inc;

    case (st_next)
      ABRIENDO: puerta_next = 2'b10;
      CERRANDO: puerta_next = 2'b01;
      default:  puerta_next = 2'b00;
    endcase
    esperar_next = (st_next != CERRADA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= CERRANDO;
      s       <= '0;
      falla   <= 1'b0;
      cnt_mov <= '0;
      cnt_esp <= '0;
      puerta  <= 2'b01;
      esperar <= 1'b1;
    end else begin
      st      <= st_next;
      s       <= s_next;
      falla   <= falla_next;
      cnt_mov <= cnt_mov_next;
      cnt_esp <= cnt_esp_next;
      puerta  <= puerta_next;
      esperar <= esperar_next;
    end
  end

endmodule

// File: tb/tb_gestor_puertas.sv
// Bench for gestor_puertas: directed floor/door scenarios followed by random traffic against a reference model.
module tb_gestor_puertas;

  localparam int T_ESPERA = 50;
  localparam int T_MOV    = 200;
  localparam int PH_CLOSED  = 0;
  localparam int PH_OPENING = 1;
  localparam int PH_OPEN    = 2;
  localparam int PH_CLOSING = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] botones = '0;
  logic [3:0] estado = '0;
  logic       fin_abierta = 1'b0;
  logic       fin_cerrada = 1'b0;
  logic       obstaculo = 1'b0;
  logic [9:0] s;
  logic       esperar;
  logic [1:0] puerta;
  logic       falla;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending requests, door phase, and absolute edge times
  bit [9:0] m_pend;
  int       m_fase;
  bit       m_falla;
  int       cyc, t_entry, t_close;

  gestor_puertas #(.T_ESPERA(T_ESPERA), .T_MOV(T_MOV)) dut (
    .clk(clk), .reset_n(reset_n), .botones(botones), .estado(estado),
    .fin_abierta(fin_abierta), .fin_cerrada(fin_cerrada), .obstaculo(obstaculo),
    .s(s), .esperar(esperar), .puerta(puerta), .falla(falla)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit [9:0] m_served(input bit [9:0] p, input int floor, input bit up);
    int cab[4];
    int hup[4];
    int hdn[4];
    bit [9:0] r;
    bit others;
    cab = '{6, 7, 8, 9};
    hup = '{0, 2, 4, -1};
    hdn = '{-1, 1, 3, 5};
    r = 10'b1 << cab[floor];
    if (floor == 0) r |= 10'b1 << hup[0];
    else if (floor == 3) r |= 10'b1 << hdn[3];
    else begin
      r |= 10'b1 << (up ? hup[floor] : hdn[floor]);
      others = 1'b0;
      for (int g = 0; g < 4; g++) begin
        if ((up && g > floor) || (!up && g < floor)) begin
          if (((p >> cab[g]) & 10'd1) != 0) others = 1'b1;
          if (hup[g] >= 0 && ((p >> hup[g]) & 10'd1) != 0) others = 1'b1;
          if (hdn[g] >= 0 && ((p >> hdn[g]) & 10'd1) != 0) others = 1'b1;
        end
      end
      if (!others) r |= 10'b1 << (up ? hdn[floor] : hup[floor]);
    end
    return r;
  endfunction

  function automatic bit [1:0] m_puerta();
    if (m_fase == PH_OPENING) return 2'b10;
    if (m_fase == PH_CLOSING) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_fase  = PH_CLOSING;
    m_falla = 1'b0;
    cyc     = 0;
    t_entry = 0;
    t_close = 0;
  endtask

  task automatic model_step();
    bit [9:0] srv, nxt;
    bit hit, obs;
    int n, nf;
    cyc = cyc + 1;
    n   = cyc;
    srv = m_served(m_pend, int'(estado[1:0]), estado[2]);
    hit = (botones & srv) != 0;
`ifdef OBSTACULO_EN
    obs = obstaculo;
`else
    obs = 1'b0;
`endif
    nxt = m_pend | botones;
    nf  = m_fase;
    case (m_fase)
      PH_CLOSED:
        if (!estado[3] && ((m_pend | botones) & srv) != 0) nf = PH_OPENING;
      PH_OPENING:
        if (fin_abierta || (n - t_entry) >= T_MOV) begin
          nf = PH_OPEN;
          if (!fin_abierta) m_falla = 1'b1;
          nxt = (m_pend | botones) & ~srv;
        end
      PH_OPEN:
        if (hit || obs) t_close = n + T_ESPERA;
        else if (n >= t_close) nf = PH_CLOSING;
      default:
        if (hit || obs) nf = PH_OPENING;
        else if (fin_cerrada && !fin_abierta) nf = PH_CLOSED;
        else if ((n - t_entry) >= T_MOV) begin
          nf = PH_OPENING;
          m_falla = 1'b1;
        end
    endcase
    if (nf != m_fase) begin
      t_entry = n;
      if (nf == PH_OPEN) t_close = n + T_ESPERA;
    end
    m_fase = nf;
    m_pend = nxt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic check_model();
    chk($sformatf("model_s@%0d", cyc), 32'(s), 32'(m_pend));
    chk($sformatf("model_puerta@%0d", cyc), 32'(puerta), 32'(m_puerta()));
    chk($sformatf("model_esperar@%0d", cyc), 32'(esperar), 32'(m_fase != PH_CLOSED));
    chk($sformatf("model_falla@%0d", cyc), 32'(falla), 32'(m_falla));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    check_model();
  endtask

  task automatic ir_cerrada(input string tag);
    int k;
    k = 0;
    botones = '0;
    obstaculo = 1'b0;
    while (!(puerta == 2'b00 && esperar == 1'b0) && k < 3000) begin
      fin_abierta = (puerta == 2'b10);
      fin_cerrada = (puerta == 2'b01);
      tick();
      k++;
    end
    chk(tag, 32'(esperar), 32'(0));
  endtask

  initial begin
    int k;
    model_reset();
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_s", 32'(s), 32'(0));
    chk("rst_puerta", 32'(puerta), 32'(2'b01));
    chk("rst_esperar", 32'(esperar), 32'(1));
    chk("rst_falla", 32'(falla), 32'(0));

    fin_cerrada = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("release_puerta", 32'(puerta), 32'(2'b00));
    chk("release_esperar", 32'(esperar), 32'(0));

    // Cabin call for another floor while parked: latched, no opening
    estado = 4'b0000;
    botones = 10'h100;
    tick();
    botones = '0;
    chk("s1_s", 32'(s), 32'(10'h100));
    repeat (5) tick();
    chk("s1_esperar", 32'(esperar), 32'(0));
    chk("s1_puerta", 32'(puerta), 32'(2'b00));

    // Arrive at floor index 2 with cabin + up-hall pending
    estado = 4'b1110;
    botones = 10'h010;
    tick();
    botones = '0;
    chk("s2_latched", 32'(s), 32'(10'h110));
    estado = 4'b0010;
    tick();
    chk("s2_abriendo", 32'(puerta), 32'(2'b10));
    fin_cerrada = 1'b0;
    fin_abierta = 1'b1;
    tick();
    fin_abierta = 1'b0;
    chk("s2_s_clear", 32'(s), 32'(0));
    chk("s2_abierta", 32'(puerta), 32'(2'b00));
    k = 1;
    while (puerta == 2'b00 && k < 1000) begin
      tick();
      if (puerta == 2'b00) k++;
    end
    chk("s2_dwell", 32'(k), 32'(T_ESPERA));
    chk("s2_cerrando", 32'(puerta), 32'(2'b01));
    fin_cerrada = 1'b1;
    tick();
    chk("s2_cerrada", 32'(puerta), 32'(2'b00));

    // Reversal: only the down call pending, nothing above
    estado = 4'b1110;
    botones = 10'h008;
    tick();
    botones = '0;
    chk("s3_latched", 32'(s), 32'(10'h008));
    estado = 4'b0110;
    tick();
    chk("s3_abriendo", 32'(puerta), 32'(2'b10));
    fin_cerrada = 1'b0;
    fin_abierta = 1'b1;
    tick();
    fin_abierta = 1'b0;
    chk("s3_s_clear", 32'(s), 32'(0));
    ir_cerrada("s3_cierre");

    // Obstruction during closing
    estado = 4'b0010;
    botones = 10'h100;
    tick();
    botones = '0;
    fin_cerrada = 1'b0;
    fin_abierta = 1'b1;
    tick();
    fin_abierta = 1'b0;
    k = 0;
    while (puerta != 2'b01 && k < 1000) begin
      tick();
      k++;
    end
    chk("s4_cerrando", 32'(puerta), 32'(2'b01));
    obstaculo = 1'b1;
    tick();
    obstaculo = 1'b0;
`ifdef OBSTACULO_EN
    chk("s4_obst", 32'(puerta), 32'(2'b10));
`else
    chk("s4_obst", 32'(puerta), 32'(2'b01));
`endif
    ir_cerrada("s4_cierre");

    // Opening stroke timeout
    estado = 4'b0010;
    fin_cerrada = 1'b0;
    fin_abierta = 1'b0;
    botones = 10'h100;
    tick();
    botones = '0;
    chk("s5_abriendo", 32'(puerta), 32'(2'b10));
    k = 1;
    while (puerta == 2'b10 && k < 1000) begin
      tick();
      if (puerta == 2'b10) k++;
    end
    chk("s5_stroke", 32'(k), 32'(T_MOV));
    chk("s5_falla", 32'(falla), 32'(1));
    chk("s5_abierta", 32'(puerta), 32'(2'b00));
    ir_cerrada("s5_cierre");

    // Asynchronous reset while open with every request pending
    botones = 10'h100;
    tick();
    botones = '0;
    fin_cerrada = 1'b0;
    fin_abierta = 1'b1;
    tick();
    fin_abierta = 1'b0;
    botones = 10'h3FF;
    tick();
    botones = '0;
    chk("s6_s_full", 32'(s), 32'(10'h3FF));
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("s6_s", 32'(s), 32'(0));
    chk("s6_puerta", 32'(puerta), 32'(2'b01));
    chk("s6_esperar", 32'(esperar), 32'(1));
    chk("s6_falla", 32'(falla), 32'(0));
    tick();
    fin_cerrada = 1'b1;
    reset_n = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 24) == 0) estado = 4'($urandom_range(0, 15));
      botones = ($urandom_range(0, 5) == 0) ? (10'b1 << $urandom_range(0, 9)) : 10'h000;
      fin_abierta = (puerta == 2'b10) ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 30) == 0);
      fin_cerrada = (puerta == 2'b01) ? ($urandom_range(0, 6) == 0) : ($urandom_range(0, 30) == 0);
      obstaculo = ($urandom_range(0, 40) == 0);
      if (i == 2000) begin
        reset_n = 1'b0;
        model_reset();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gestor_puertas.md
GESTOR_PUERTAS -- requirements
Module: gestor_puertas

Interface
REQ-001 Parameter T_ESPERA, default 50: door dwell time in clk cycles once fully open; legal range 1..255.
REQ-002 Parameter T_MOV, default 200: maximum clk cycles allowed for a door opening or closing stroke; legal range 1..1023.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 botones  input  10  button levels, synchronous to clk. [0] floor 1 up, [1] floor 2 down, [2] floor 2 up, [3] floor 3 down, [4] floor 3 up, [5] floor 4 down, [9:6] cabin floors 4..1.
REQ-006 estado  input  4  car state. [3] moving, [2] direction up, [1:0] floor 0..3.
REQ-007 fin_abierta  input  1  door fully-open limit switch.
REQ-008 fin_cerrada  input  1  door fully-closed limit switch.
REQ-009 obstaculo  input  1  door-edge obstruction sensor.
REQ-010 s  output  10  latched pending requests, same bit map as botones.
REQ-011 esperar  output  1  car shall not move.
REQ-012 puerta  output  2  door motor command: 00 stop, 10 open, 01 close.
REQ-013 falla  output  1  sticky door-stroke timeout flag.

Function
REQ-014 s[i] shall set on the rising clk edge after botones[i]=1; it stays set until cleared by REQ-016.
REQ-015 Served set for the current floor f = estado[1:0], direction d = estado[2]:
- cabin bit of f
- the hall bit of f matching d; floor 1 uses s[0] and floor 4 uses s[5] regardless of d
- the opposite hall bit of f as well, when no s bit for any floor strictly beyond f in direction d is set.
REQ-016 The served set shall be cleared in s on the edge at which the FSM leaves ABRIENDO; a botones bit in the served set that is high on that edge shall not be latched.
REQ-017 FSM states: CERRADA, ABRIENDO, ABIERTA, CERRANDO.
REQ-018 CERRADA->ABRIENDO when estado[3]=0 and any served-set bit is set in s or in botones; otherwise remain in CERRADA.
REQ-019 ABRIENDO->ABIERTA on fin_abierta=1 or after T_MOV cycles in ABRIENDO; the timeout also sets falla.
REQ-020 ABIERTA: the dwell counter loads T_ESPERA on entry and decrements each cycle. A served-set press in botones reloads it. At 0 the FSM goes to CERRANDO.
REQ-021 CERRANDO->CERRADA on fin_cerrada=1. After T_MOV cycles without fin_cerrada the FSM goes to ABRIENDO and sets falla. A served-set press in CERRANDO also goes to ABRIENDO.
REQ-022 puerta shall be 10 in ABRIENDO, 00 in ABIERTA and CERRADA, and 01 in CERRANDO; all outputs are registered.
REQ-023 esperar shall be 1 in every state except CERRADA, and 1 in CERRADA on any cycle where the REQ-018 condition holds.
REQ-024 When estado[3]=1 while the FSM is not in CERRADA, the FSM shall ignore it and continue its sequence; esperar stays 1.
REQ-025 When fin_abierta and fin_cerrada are both 1, the block shall treat the door as not closed: CERRANDO does not exit.
REQ-026 The stroke counter shall clear on every state change and saturate at T_MOV.

Reset
REQ-027 While reset_n=0: s=0, falla=0, counters=0, FSM=CERRANDO, puerta=01, esperar=1; this applies asynchronously, including mid-stroke.
REQ-028 On the first edge after release, the FSM shall move to CERRADA if fin_cerrada=1; otherwise REQ-021 applies.

Configuration
REQ-029 Macro OBSTACULO_EN defined: obstaculo=1 in CERRANDO shall force ABRIENDO on the next edge, and obstaculo=1 in ABIERTA shall hold the dwell counter at T_ESPERA.
REQ-030 Macro OBSTACULO_EN undefined: the obstaculo port exists but is ignored.

Verification
REQ-031 Scenario 1: reset, then estado=0000 and botones[8]=1 for 1 cycle -> s[8]=1. No open occurs; esperar stays 0.
REQ-032 Scenario 2: estado goes 1110 -> 0010 with s={8,4} -> ABRIENDO. fin_abierta -> s[8] and s[4] clear, s[3] is untouched, puerta=00 for exactly T_ESPERA cycles, then 01.
REQ-033 Scenario 3: stopped at floor 3 going up with only s[3] set (nothing above) -> s[3] clears (reversal rule).
REQ-034 Scenario 4: with OBSTACULO_EN defined, pulse obstaculo during CERRANDO -> puerta 01 -> 10 on the next edge. With OBSTACULO_EN undefined, the same pulse -> puerta stays 01.
REQ-035 Scenario 5: hold fin_abierta=0 in ABRIENDO -> after 200 cycles falla=1 and the FSM goes to ABIERTA.
REQ-036 Scenario 6: assert reset_n=0 in ABIERTA with s=3FF -> s=000, puerta=01 and esperar=1 immediately, without waiting for a clock edge.
